// File: rtl/demux_1to2_stream_pkg.sv
// Shared defaults and helpers for the 1-to-2 stream demux.
// Imported by the FIFO and the top level.
package demux_1to2_stream_pkg;

  localparam int DEMUX_WIDTH_DEF = 32;
  localparam int DEMUX_DEPTH_DEF = 2;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/demux_out_fifo.sv
// Per-output show-ahead FIFO with occupancy count.
// The storage array is deliberately left out of reset.
module demux_out_fifo
  import demux_1to2_stream_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF,
  parameter int DEPTH = DEMUX_DEPTH_DEF,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == FULL_CNT);
  assign valid = (count != '0);

  // Guard locally so a misbehaving caller cannot corrupt the count.
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;

  assign head_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_1to2_stream.sv
// 1-to-2 stream demux: one producer, two independently
// buffered consumers; a stall on one side never blocks the other.
module demux_1to2_stream
  import demux_1to2_stream_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF,
  parameter int DEPTH = DEMUX_DEPTH_DEF,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CW-1:0]    out0_count,
  output logic [CW-1:0]    out1_count
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;
  logic xfer;

  // Ready depends only on the selected FIFO's fill state.
  assign in_ready = in_sel ? !full1 : !full0;
  assign xfer     = in_valid && in_ready;
  assign push0    = xfer && !in_sel;
  assign push1    = xfer && in_sel;

  demux_out_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo0 (
    .clk      (clk),
    .rst      (rst),
    .push     (push0),
    .push_data(in_data),
    .pop      (out0_ready),
    .full     (full0),
    .valid    (out0_valid),
    .head_data(out0_data),
    .count    (out0_count)
  );

  demux_out_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo1 (
    .clk      (clk),
    .rst      (rst),
    .push     (push1),
    .push_data(in_data),
    .pop      (out1_ready),
    .full     (full1),
    .valid    (out1_valid),
    .head_data(out1_data),
    .count    (out1_count)
  );

endmodule
